// File: rtl/lb_bus_pkg.sv
// Shared encodings, FSM states and lane helpers for the 68040 local-bus sizer.
package lb_bus_pkg;

   // Decoded target port width presented with TS_CPUn.
   typedef enum logic [1:0] {
      PS_32  = 2'b00,
      PS_16  = 2'b01,
      PS_8   = 2'b10,
      PS_32B = 2'b11
   } portsize_e;

   // 68040 SIZ encoding; a line transfer is handled as a single long.
   typedef enum logic [1:0] {
      SIZ_LONG = 2'b00,
      SIZ_BYTE = 2'b01,
      SIZ_WORD = 2'b10,
      SIZ_LINE = 2'b11
   } siz_e;

   // Sub-cycle sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_NEXT  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_e;

   // Number of bytes moved by one CPU transfer.
   function automatic logic [2:0] bytes_of(input logic [1:0] siz);
      logic [2:0] b;
      case (siz)
         SIZ_BYTE: b = 3'd1;
         SIZ_WORD: b = 3'd2;
         default:  b = 3'd4;
      endcase
      return b;
   endfunction

   // Port width in bytes.
   function automatic logic [2:0] pw_of(input logic [1:0] ps);
      logic [2:0] w;
      case (ps)
         PS_16:   w = 3'd2;
         PS_8:    w = 3'd1;
         default: w = 3'd4;
      endcase
      return w;
   endfunction

   // Index of the last sub-cycle: max(1, bytes/pw) - 1.
   function automatic logic [1:0] last_sub(input logic [2:0] bytes, input logic [2:0] pw);
      logic [2:0] t;
      t = bytes - 3'd1;
      if (bytes <= pw) begin
         return 2'd0;
      end else if (pw == 3'd2) begin
         return 2'd1;
      end else begin
         return t[1:0];
      end
   endfunction

   // Bit shift that moves byte 'offset' of the CPU bus onto the upper port lanes.
   // A 32-bit port already sits on its natural lanes, so it never shifts.
   function automatic logic [4:0] lane_shift(input logic [1:0] offset, input logic [2:0] pw);
      if (pw == 3'd4) begin
         return 5'd0;
      end else begin
         return {offset, 3'b000};
      end
   endfunction

endpackage

// File: rtl/lb_lane_router.sv
// Combinational lane steering between the CPU byte image and a sized port.
module lb_lane_router
   import lb_bus_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  pw,
   input  logic [31:0] wr_in,
   input  logic [31:0] rd_in,
   output logic [31:0] wr_out,
   output logic [31:0] rd_out,
   output logic [3:0]  rd_mask
);

   // Shift write bytes up to the port lanes, read lanes back down to their offset,
   // and flag which accumulator bytes this sub-cycle supplies (bit 3 = D[31:24]).
   always_comb begin
      logic [4:0] sh;
      sh     = lane_shift(off, pw);
      wr_out = wr_in << sh;
      rd_out = rd_in >> sh;
      case (pw)
         3'd4:    rd_mask = 4'b1111;
         3'd2:    rd_mask = 4'b1100 >> off;
         default: rd_mask = 4'b1000 >> off;
      endcase
   end

endmodule

// File: rtl/lb_dynamic_bus_sizer.sv
// Splits one 68040 transfer into 1, 2 or 4 local sub-cycles for 32/16/8-bit ports,
// reassembles read data, routes write lanes and times out a missing TACKn.
//
// Local handshake: TSn is low for exactly one clock (START) to open a sub-cycle; the
// port completes it by pulling TACKn low during any WAIT clock, and TACKn is ignored in
// every other state. The CPU side sees exactly one TAn (or TEAn) pulse per transfer.
module lb_dynamic_bus_sizer
   import lb_bus_pkg::*;
#(
   parameter int TIMEOUT_CYC = 256,
   parameter int CNT_W       = 9
) (
   input  logic        CLK80,
   input  logic        RESET,
   input  logic        TS_CPUn,
   input  logic        RnW,
   input  logic [1:0]  SIZ,
   input  logic [1:0]  A_040,
   input  logic [1:0]  PORTSIZE,
   input  logic [31:0] D_CPU_I,
   output logic [31:0] D_CPU_O,
   output logic        D_CPU_OE,
   output logic        TAn,
   output logic        TEAn,
   output logic        TBI_CPUn,
   output logic        TSn,
   output logic [1:0]  A_LOCAL,
   input  logic        TACKn,
   input  logic [31:0] D_LOC_I,
   output logic [31:0] D_LOC_O,
   output logic        D_LOC_OE,
   output state_e      state_dbg
);

   localparam logic [CNT_W:0] TO_LIM  = (CNT_W+1)'(TIMEOUT_CYC);
   localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic              rnw_q;
   logic [1:0]        siz_q, addr_q, ps_q, k_q, last_k_q;
   logic [31:0]       wdata_q, acc_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [2:0]        pw;
   logic [1:0]        off;
   logic [31:0]       wr_lanes, rd_lanes;
   logic [3:0]        rd_mask;
   logic [CNT_W:0]    cnt_inc;
   logic              timeout_hit;
   logic              passthru;
   logic              capture;

   assign pw          = pw_of(ps_q);
   assign off         = addr_q + k_q * pw[1:0];
   assign cnt_inc     = {1'b0, cnt_q} + CNT_ONE;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc >= TO_LIM);
   assign capture     = (state_q == ST_IDLE) && !TS_CPUn;
   // Byte/word reads from a 32-bit port come straight off the local bus.
   assign passthru    = (pw == 3'd4) && ((siz_q == SIZ_BYTE) || (siz_q == SIZ_WORD));
   assign state_dbg   = state_q;

   lb_lane_router u_router (
      .off     (off),
      .pw      (pw),
      .wr_in   (wdata_q),
      .rd_in   (D_LOC_I),
      .wr_out  (wr_lanes),
      .rd_out  (rd_lanes),
      .rd_mask (rd_mask)
   );

   // State register.
   always_ff @(posedge CLK80) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and bus strobe decode.
   always_comb begin
      state_d  = state_q;
      TSn      = 1'b1;
      TAn      = 1'b1;
      TEAn     = 1'b1;
      TBI_CPUn = 1'b1;
      D_CPU_OE = 1'b0;
      D_LOC_OE = 1'b0;
      A_LOCAL  = off;
      D_LOC_O  = wr_lanes;
      D_CPU_O  = passthru ? D_LOC_I : acc_q;
      case (state_q)
         ST_IDLE: begin
            if (!TS_CPUn) state_d = ST_START;
         end
         ST_START: begin
            TSn      = 1'b0;
            D_LOC_OE = ~rnw_q;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            D_LOC_OE = ~rnw_q;
            if (!TACKn) begin
               state_d = (k_q == last_k_q) ? ST_DONE : ST_NEXT;
            end else if (timeout_hit) begin
               state_d = ST_ERR;
            end
         end
         ST_NEXT: state_d = ST_START;
         ST_DONE: begin
            TAn      = 1'b0;
            TBI_CPUn = 1'b0;
            D_CPU_OE = rnw_q;
            state_d  = ST_IDLE;
         end
         ST_ERR: begin
            TEAn    = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Transfer capture, sub-cycle/timeout counting and read accumulation.
   // The timeout counter measures clocks since the current TSn pulse began.
   always_ff @(posedge CLK80) begin
      if (RESET) begin
         rnw_q    <= 1'b0;
         siz_q    <= 2'b00;
         addr_q   <= 2'b00;
         ps_q     <= 2'b00;
         wdata_q  <= '0;
         acc_q    <= '0;
         k_q      <= 2'd0;
         last_k_q <= 2'd0;
         cnt_q    <= '0;
      end else if (capture) begin
         rnw_q    <= RnW;
         siz_q    <= SIZ;
         addr_q   <= A_040;
         ps_q     <= PORTSIZE;
         wdata_q  <= D_CPU_I;
         acc_q    <= '0;
         k_q      <= 2'd0;
         last_k_q <= last_sub(bytes_of(SIZ), pw_of(PORTSIZE));
         cnt_q    <= '0;
      end else begin
         case (state_q)
            ST_START: cnt_q <= cnt_inc[CNT_W-1:0];
            ST_WAIT: begin
               cnt_q <= cnt_inc[CNT_W-1:0];
               if (!TACKn && rnw_q) begin
                  for (int b = 0; b < 4; b++) begin
                     if (rd_mask[b]) acc_q[8*b +: 8] <= rd_lanes[8*b +: 8];
                  end
               end
            end
            ST_NEXT: begin
               k_q   <= k_q + 2'd1;
               cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   // The 68040 never starts a transfer while one is outstanding.
   ts_while_busy: assert property (@(posedge CLK80) disable iff (RESET)
      (state_q != ST_IDLE) |-> TS_CPUn)
      else $error("TS_CPUn asserted during an active transfer");

endmodule

// File: tb/tb_lb_dynamic_bus_sizer.sv
// Directed bench for lb_dynamic_bus_sizer with hand-computed expectations.
module tb_lb_dynamic_bus_sizer;
   import lb_bus_pkg::*;

   logic        CLK80 = 1'b0;
   logic        RESET, TS_CPUn, RnW, TACKn;
   logic [1:0]  SIZ, A_040, PORTSIZE, A_LOCAL;
   logic [31:0] D_CPU_I, D_CPU_O, D_LOC_I, D_LOC_O;
   logic        D_CPU_OE, TAn, TEAn, TBI_CPUn, TSn, D_LOC_OE;
   state_e      state_dbg;

   int checks   = 0;
   int failures = 0;

   // Clock and watchdog.
   always #5 CLK80 = ~CLK80;

   initial begin
      #100000;
      $display("FAIL watchdog observed=running required=finished");
      $fatal(1, "bench time limit expired");
   end

   lb_dynamic_bus_sizer #(.TIMEOUT_CYC(8), .CNT_W(9)) dut (
      .CLK80     (CLK80),
      .RESET     (RESET),
      .TS_CPUn   (TS_CPUn),
      .RnW       (RnW),
      .SIZ       (SIZ),
      .A_040     (A_040),
      .PORTSIZE  (PORTSIZE),
      .D_CPU_I   (D_CPU_I),
      .D_CPU_O   (D_CPU_O),
      .D_CPU_OE  (D_CPU_OE),
      .TAn       (TAn),
      .TEAn      (TEAn),
      .TBI_CPUn  (TBI_CPUn),
      .TSn       (TSn),
      .A_LOCAL   (A_LOCAL),
      .TACKn     (TACKn),
      .D_LOC_I   (D_LOC_I),
      .D_LOC_O   (D_LOC_O),
      .D_LOC_OE  (D_LOC_OE),
      .state_dbg (state_dbg)
   );

   // Driver tasks: outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge CLK80);
      #1;
   endtask

   task automatic capture(input logic rnw, input logic [1:0] siz, input logic [1:0] a,
                          input logic [1:0] ps, input logic [31:0] d);
      RnW      = rnw;
      SIZ      = siz;
      A_040    = a;
      PORTSIZE = ps;
      D_CPU_I  = d;
      TS_CPUn  = 1'b0;
      tick();
      TS_CPUn  = 1'b1;
   endtask

   task automatic ack(input logic [31:0] d);
      TACKn   = 1'b0;
      D_LOC_I = d;
      tick();
      TACKn   = 1'b1;
   endtask

   // Scoreboard comparisons.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input state_e exp);
      checks++;
      assert (state_dbg === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, state_dbg, exp);
      end
   endtask

   logic [7:0] wr_bytes [4];

   initial begin
      wr_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      RESET    = 1'b1;
      TS_CPUn  = 1'b1;
      TACKn    = 1'b1;
      RnW      = 1'b1;
      SIZ      = 2'b00;
      A_040    = 2'd0;
      PORTSIZE = 2'b00;
      D_CPU_I  = '0;
      D_LOC_I  = '0;
      tick();
      tick();

      // Reset values.
      chk_bit("rst_tsn", TSn, 1'b1);
      chk_bit("rst_tan", TAn, 1'b1);
      chk_bit("rst_tean", TEAn, 1'b1);
      chk_bit("rst_tbi", TBI_CPUn, 1'b1);
      chk_bit("rst_cpu_oe", D_CPU_OE, 1'b0);
      chk_bit("rst_loc_oe", D_LOC_OE, 1'b0);
      chk("rst_a_local", 32'(A_LOCAL), 32'd0);
      chk_state("rst_state", ST_IDLE);
      RESET = 1'b0;
      tick();

      // Long read, 32-bit port.
      capture(1'b1, 2'b00, 2'd0, 2'b00, 32'h0);
      chk_bit("t1_tsn_start", TSn, 1'b0);
      chk("t1_a_local", 32'(A_LOCAL), 32'd0);
      chk_bit("t1_loc_oe", D_LOC_OE, 1'b0);
      tick();
      chk_bit("t1_tsn_wait", TSn, 1'b1);
      chk_state("t1_wait", ST_WAIT);
      ack(32'h11223344);
      chk_bit("t1_tan", TAn, 1'b0);
      chk_bit("t1_tbi", TBI_CPUn, 1'b0);
      chk_bit("t1_cpu_oe", D_CPU_OE, 1'b1);
      chk("t1_data", D_CPU_O, 32'h11223344);
      tick();
      chk_bit("t1_tan_end", TAn, 1'b1);
      chk_bit("t1_cpu_oe_end", D_CPU_OE, 1'b0);
      chk_state("t1_idle", ST_IDLE);

      // Long read, 16-bit port, two sub-cycles.
      capture(1'b1, 2'b00, 2'd0, 2'b01, 32'h0);
      chk_bit("t2_tsn0", TSn, 1'b0);
      chk("t2_a0", 32'(A_LOCAL), 32'd0);
      tick();
      ack(32'hAABB0000);
      chk_state("t2_next", ST_NEXT);
      chk_bit("t2_tsn_next", TSn, 1'b1);
      chk_bit("t2_tan_next", TAn, 1'b1);
      tick();
      chk_bit("t2_tsn1", TSn, 1'b0);
      chk("t2_a1", 32'(A_LOCAL), 32'd2);
      tick();
      ack(32'hCCDD0000);
      chk_bit("t2_tan", TAn, 1'b0);
      chk("t2_data", D_CPU_O, 32'hAABBCCDD);
      tick();

      // Long write, 8-bit port, four sub-cycles.
      capture(1'b0, 2'b00, 2'd0, 2'b10, 32'hDEADBEEF);
      for (int k = 0; k < 4; k++) begin
         chk_bit($sformatf("t3_tsn_%0d", k), TSn, 1'b0);
         chk($sformatf("t3_a_%0d", k), 32'(A_LOCAL), 32'(k));
         chk($sformatf("t3_lane_%0d", k), 32'(D_LOC_O[31:24]), 32'(wr_bytes[k]));
         chk_bit($sformatf("t3_oe_start_%0d", k), D_LOC_OE, 1'b1);
         tick();
         chk_bit($sformatf("t3_oe_wait_%0d", k), D_LOC_OE, 1'b1);
         chk_bit($sformatf("t3_tan_wait_%0d", k), TAn, 1'b1);
         ack(32'h0);
         if (k < 3) begin
            chk_state($sformatf("t3_next_%0d", k), ST_NEXT);
            chk_bit($sformatf("t3_tan_next_%0d", k), TAn, 1'b1);
            tick();
         end
      end
      chk_bit("t3_tan", TAn, 1'b0);
      chk_bit("t3_loc_oe_done", D_LOC_OE, 1'b0);
      chk_bit("t3_cpu_oe_done", D_CPU_OE, 1'b0);
      tick();

      // Word write at address 2, 16-bit port.
      capture(1'b0, 2'b10, 2'd2, 2'b01, 32'h00001234);
      chk("t4_a", 32'(A_LOCAL), 32'd2);
      chk("t4_lanes", 32'(D_LOC_O[31:16]), 32'h1234);
      tick();
      ack(32'h0);
      chk_bit("t4_tan", TAn, 1'b0);
      tick();

      // Long read, 16-bit port, second sub-cycle never acknowledged.
      capture(1'b1, 2'b00, 2'd0, 2'b01, 32'h0);
      tick();
      ack(32'h11110000);
      chk_state("t5_next", ST_NEXT);
      tick();
      chk_bit("t5_tsn", TSn, 1'b0);
      chk("t5_a", 32'(A_LOCAL), 32'd2);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk_bit($sformatf("t5_tean_hi_%0d", i), TEAn, 1'b1);
         chk_state($sformatf("t5_wait_%0d", i), ST_WAIT);
      end
      tick();
      chk_bit("t5_tean", TEAn, 1'b0);
      chk_bit("t5_tan", TAn, 1'b1);
      chk_bit("t5_cpu_oe", D_CPU_OE, 1'b0);
      tick();
      chk_bit("t5_tean_end", TEAn, 1'b1);
      chk_state("t5_idle", ST_IDLE);

      // Reset in the WAIT of the second of four write sub-cycles.
      capture(1'b0, 2'b00, 2'd0, 2'b10, 32'hCAFEF00D);
      tick();
      ack(32'h0);
      tick();
      chk("t6_a1", 32'(A_LOCAL), 32'd1);
      tick();
      chk_bit("t6_oe_wait", D_LOC_OE, 1'b1);
      chk_state("t6_wait", ST_WAIT);
      RESET = 1'b1;
      tick();
      chk_state("t6_rst_state", ST_IDLE);
      chk_bit("t6_rst_tsn", TSn, 1'b1);
      chk_bit("t6_rst_tan", TAn, 1'b1);
      chk_bit("t6_rst_tean", TEAn, 1'b1);
      chk_bit("t6_rst_tbi", TBI_CPUn, 1'b1);
      chk_bit("t6_rst_loc_oe", D_LOC_OE, 1'b0);
      chk_bit("t6_rst_cpu_oe", D_CPU_OE, 1'b0);
      chk("t6_rst_a", 32'(A_LOCAL), 32'd0);
      chk("t6_rst_dloc", D_LOC_O, 32'h0);
      chk("t6_rst_dcpu", D_CPU_O, 32'h0);
      RESET = 1'b0;
      tick();

      // New transfer after reset: word read at address 2 on a 32-bit port.
      capture(1'b1, 2'b10, 2'd2, 2'b00, 32'h0);
      chk_bit("t7_tsn", TSn, 1'b0);
      chk("t7_a", 32'(A_LOCAL), 32'd2);
      tick();
      ack(32'h00005678);
      chk_bit("t7_tan", TAn, 1'b0);
      chk_bit("t7_cpu_oe", D_CPU_OE, 1'b1);
      chk("t7_data", D_CPU_O, 32'h00005678);
      tick();
      chk_bit("t7_tan_end", TAn, 1'b1);

      // Final report.
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
